// File: rtl/chargen_src_pkg.sv
// +------------------------------------------------------------------+
// | chargen_src_pkg : shared ASCII constants and FSM state encoding  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package chargen_src_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHAR = 2'd1,
    CR   = 2'd2,
    LF   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/chargen_src_mod_counter.sv
// +------------------------------------------------------------------+
// | mod_counter : modulo-MOD counter with load; exposes its next     |
// | value so the owner can register data derived from it same-edge.  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mod_counter #(
  parameter int MOD = 95,
  parameter int W   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q_nxt
);

  localparam logic [W-1:0] C_MAX = W'(MOD - 1);

  logic [W-1:0] r_q;

  // load has priority over inc
  always_comb begin
    q_nxt = r_q;
    if (load) begin
      q_nxt = load_val;
    end else if (inc) begin
      q_nxt = (r_q == C_MAX) ? '0 : r_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= q_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/chargen_src.sv
// +------------------------------------------------------------------+
// | chargen_src : RFC 864 character generator feeding a byte sink    |
// | over an active-low valid/ready handshake. rev 1.0                |
// +------------------------------------------------------------------+
`default_nettype none

module chargen_src
  import chargen_src_pkg::*;
#(
  parameter int         LINE_LEN = 72,
  parameter logic [7:0] FIRST_CH = ASCII_SP,
  parameter int         NCHARS   = 95
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ready_n,
  output logic [7:0]  data,
  output logic        valid_n,
  output logic [15:0] line_cnt
);

  localparam logic [7:0] C_LAST_COL = 8'(LINE_LEN - 1);

  state_t      r_state;
  state_t      r_pend;
  logic        r_valid_n;
  logic [7:0]  r_data;
  logic [7:0]  r_col;
  logic [15:0] r_line_cnt;

  state_t      w_state_nxt;
  state_t      w_pend_nxt;
  state_t      w_kind;
  logic        w_valid_n_nxt;
  logic [7:0]  w_data_nxt;
  logic [7:0]  w_col_nxt;
  logic        w_xfer;
  logic        w_advance;
  logic        w_cur_inc;
  logic        w_cur_load;
  logic        w_line_inc;
  logic        w_cnt_inc;
  logic [6:0]  w_cur_nxt;
  logic [6:0]  w_line_nxt;

  assign w_xfer = !r_valid_n && !ready_n;

  mod_counter #(.MOD(NCHARS), .W(7)) u_cur_off (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_cur_inc),
    .load     (w_cur_load),
    .load_val (w_line_nxt),
    .q_nxt    (w_cur_nxt)
  );

  mod_counter #(.MOD(NCHARS), .W(7)) u_line_off (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_line_inc),
    .load     (`FALSE),
    .load_val (7'd0),
    .q_nxt    (w_line_nxt)
  );

  // Sequencing: which byte kind comes next and which counters step.
  always_comb begin
    w_kind     = r_pend;
    w_advance  = `FALSE;
    w_col_nxt  = r_col;
    w_cur_inc  = `FALSE;
    w_cur_load = `FALSE;
    w_line_inc = `FALSE;
    w_cnt_inc  = `FALSE;
    unique case (r_state)
      IDLE: begin
        w_advance = en;
      end
      CHAR: begin
        if (w_xfer) begin
          w_advance = `TRUE;
          w_cur_inc = `TRUE;
          w_col_nxt = r_col + 8'd1;
          w_kind    = (r_col == C_LAST_COL) ? CR : CHAR;
        end
      end
      CR: begin
        if (w_xfer) begin
          w_advance = `TRUE;
          w_kind    = LF;
        end
      end
      LF: begin
        if (w_xfer) begin
          w_advance  = `TRUE;
          w_line_inc = `TRUE;
          w_cur_load = `TRUE;
          w_col_nxt  = 8'd0;
          w_cnt_inc  = `TRUE;
          w_kind     = CHAR;
        end
      end
      default: ;
    endcase
  end

  // Offer the next byte, or park in IDLE remembering what was due.
  always_comb begin
    w_state_nxt   = r_state;
    w_pend_nxt    = r_pend;
    w_valid_n_nxt = r_valid_n;
    w_data_nxt    = r_data;
    if (w_advance) begin
      if (en) begin
        w_state_nxt   = w_kind;
        w_valid_n_nxt = `FALSE;
        unique case (w_kind)
          CR:      w_data_nxt = ASCII_CR;
          LF:      w_data_nxt = ASCII_LF;
          default: w_data_nxt = FIRST_CH + {1'b0, w_cur_nxt};
        endcase
      end else begin
        w_state_nxt   = IDLE;
        w_pend_nxt    = w_kind;
        w_valid_n_nxt = `TRUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= CHAR;
      r_valid_n  <= 1'b1;
      r_data     <= 8'h00;
      r_col      <= 8'd0;
      r_line_cnt <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend    <= w_pend_nxt;
      r_valid_n <= w_valid_n_nxt;
      r_data    <= w_data_nxt;
      r_col     <= w_col_nxt;
      if (w_cnt_inc) begin
        r_line_cnt <= r_line_cnt + 16'd1;
      end
    end
  end

  assign data     = r_data;
  assign valid_n  = r_valid_n;
  assign line_cnt = r_line_cnt;

endmodule

`default_nettype wire

// File: tb/tb_chargen_src.sv
// +------------------------------------------------------------------+
// | tb_chargen_src : directed self-checking bench for chargen_src    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_chargen_src;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ready_n;
  logic [7:0]  data;
  logic        valid_n;
  logic [15:0] line_cnt;

  int n_total = 0;
  int n_pass  = 0;

  chargen_src dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ready_n  (ready_n),
    .data     (data),
    .valid_n  (valid_n),
    .line_cnt (line_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Take one byte: drop ready_n, wait (bounded) for valid_n, capture, clock it in.
  task automatic get_byte(output logic [7:0] b, output int waits);
    waits   = 0;
    ready_n = 1'b0;
    while (valid_n !== 1'b0 && waits < 50) begin
      step();
      waits++;
    end
    if (valid_n !== 1'b0) begin
      check("get_byte_timeout", {31'd0, valid_n}, 32'd0);
    end
    b = data;
    step();
  endtask

  function automatic logic [7:0] exp_byte(input int line, input int idx);
    logic [31:0] v;
    if (idx < 72)       v = 32'h20 + ((line + idx) % 95);
    else if (idx == 72) v = 32'h0D;
    else                v = 32'h0A;
    return v[7:0];
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b0;
    ready_n = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    en  = 1'b1;
    step();
  endtask

  logic [7:0] b;
  int         w;
  int         errs;
  int         bubbles;

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    ready_n = 1'b1;
    repeat (3) step();
    check("rst_valid_n", {31'd0, valid_n}, 32'd1);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_line_cnt", {16'd0, line_cnt}, 32'd0);

    // first line
    rst = 1'b0;
    en  = 1'b1;
    ready_n = 1'b0;
    step();
    check("first_valid_n", {31'd0, valid_n}, 32'd0);
    check("first_data", {24'd0, data}, 32'h20);
    bubbles = 0;
    for (int i = 0; i < 74; i++) begin
      get_byte(b, w);
      bubbles += w;
      check($sformatf("line0_b%0d", i), {24'd0, b}, {24'd0, exp_byte(0, i)});
    end
    check("line0_bubbles", bubbles, 32'd0);
    check("line0_cnt", {16'd0, line_cnt}, 32'd1);
    get_byte(b, w);
    check("line1_first", {24'd0, b}, 32'h21);

    // wrap of the start character
    do_reset();
    errs = 0;
    for (int l = 0; l < 94; l++) begin
      for (int i = 0; i < 74; i++) begin
        get_byte(b, w);
        if (b !== exp_byte(l, i) || w != 0) errs++;
      end
    end
    check("wrap_lines_errs", errs, 32'd0);
    check("wrap_cnt94", {16'd0, line_cnt}, 32'd94);
    get_byte(b, w);
    check("line94_b0", {24'd0, b}, 32'h7E);
    get_byte(b, w);
    check("line94_b1", {24'd0, b}, 32'h20);
    get_byte(b, w);
    check("line94_b2", {24'd0, b}, 32'h21);
    errs = 0;
    for (int i = 3; i < 74; i++) begin
      get_byte(b, w);
      if (b !== exp_byte(94, i)) errs++;
    end
    check("line94_rest_errs", errs, 32'd0);
    check("wrap_cnt95", {16'd0, line_cnt}, 32'd95);
    get_byte(b, w);
    check("line95_first", {24'd0, b}, 32'h20);

    // backpressure on the 5th byte
    do_reset();
    for (int i = 0; i < 4; i++) get_byte(b, w);
    ready_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid_n !== 1'b0 || data !== 8'h24) errs++;
    end
    check("bp_hold_errs", errs, 32'd0);
    get_byte(b, w);
    check("bp_release_byte", {24'd0, b}, 32'h24);
    check("bp_release_wait", w, 32'd0);
    get_byte(b, w);
    check("bp_next_byte", {24'd0, b}, 32'h25);
    check("bp_next_wait", w, 32'd0);

    // en drop while 8'h30 is offered and stalled
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      get_byte(b, w);
      if (b !== 8'(8'h26 + i)) errs++;
    end
    check("pre30_errs", errs, 32'd0);
    ready_n = 1'b1;
    en      = 1'b0;
    repeat (3) step();
    check("endrop_valid_n", {31'd0, valid_n}, 32'd0);
    check("endrop_data", {24'd0, data}, 32'h30);
    ready_n = 1'b0;
    step();
    check("endrop_idle", {31'd0, valid_n}, 32'd1);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid_n !== 1'b1) errs++;
    end
    check("endrop_idle_errs", errs, 32'd0);
    en = 1'b1;
    get_byte(b, w);
    check("resume_byte", {24'd0, b}, 32'h31);

    // en drop on the last character of the line
    errs = 0;
    for (int i = 0; i < 53; i++) begin
      get_byte(b, w);
      if (b !== 8'(8'h32 + i)) errs++;
    end
    check("pre_cr_errs", errs, 32'd0);
    check("last_char", {24'd0, data}, 32'h67);
    en = 1'b0;
    step();
    check("cr_idle", {31'd0, valid_n}, 32'd1);
    check("cr_idle_cnt", {16'd0, line_cnt}, 32'd0);
    repeat (5) step();
    en = 1'b1;
    get_byte(b, w);
    check("resume_cr", {24'd0, b}, 32'h0D);
    get_byte(b, w);
    check("resume_lf", {24'd0, b}, 32'h0A);
    check("resume_cnt", {16'd0, line_cnt}, 32'd1);
    get_byte(b, w);
    check("resume_line1", {24'd0, b}, 32'h21);

    // reset mid-line with 8'h40 offered
    for (int i = 0; i < 30; i++) get_byte(b, w);
    ready_n = 1'b1;
    check("pre_rst_data", {24'd0, data}, 32'h40);
    rst = 1'b1;
    step();
    check("midrst_valid_n", {31'd0, valid_n}, 32'd1);
    check("midrst_cnt", {16'd0, line_cnt}, 32'd0);
    rst     = 1'b0;
    en      = 1'b1;
    ready_n = 1'b0;
    step();
    check("post_rst_valid_n", {31'd0, valid_n}, 32'd0);
    check("post_rst_data", {24'd0, data}, 32'h20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
